udp_tx_arbiter: RTL and testbench
=================================

// Module: udp_tx_arbiter
// PURPOSE
// - Shares the single UDP TX header+payload path of udp_complete_wrapper between PORT_COUNT application senders.
// - Sits between the application endpoints (axis master, loopback, spam, ...) and the UDP TX sink.
// - Frame-granular round-robin arbitration: header and full payload pass as one unit.
// - A stall watchdog cuts off a sender that stalls mid-frame, marks the frame bad and drains the rest.
// PARAMETERS
// - PORT_COUNT      3     number of requesters, 2..16
// - TIMEOUT_CYCLES  1024  max consecutive granted-payload cycles with tvalid low before abort; 0 disables
// - CNT_W           $clog2(TIMEOUT_CYCLES+1)  watchdog counter width (derived, localparam)
// PORTS
// - clk                 in   1   system clock
// - reset               in   1   asynchronous, active-high reset
// - udp_tx_header_if_sink   UDP_TX_HEADER_IF.Sink [PORT_COUNT]  requester headers
// - udp_tx_payload_if_sink  AXIS_IF.Slave [PORT_COUNT]  requester payloads, 8b tdata, tuser[0]=bad
// - udp_tx_header_if_source UDP_TX_HEADER_IF.Source  merged header to UDP TX
// - udp_tx_payload_if_source AXIS_IF.Master  merged payload to UDP TX
// - grant_idx           out  $clog2(PORT_COUNT)  index of current/last granted requester
// - busy                out  1   state != IDLE
// - timeout_pulse       out  1   1-cycle strobe when a watchdog abort starts
// BEHAVIOUR
// - Reset values: state=IDLE, grant_idx=PORT_COUNT-1 (so port 0 wins first), busy=0, timeout_pulse=0.
//   Also at reset: all hdr_ready/tready=0, source hdr_valid=0, source tvalid=0, watchdog=0.
// - States: IDLE -> HDR -> PAYLOAD -> IDLE. Abort path: PAYLOAD -> ABORT -> DRAIN -> IDLE.
// - IDLE: rotating priority starting at grant_idx+1 (wraps at PORT_COUNT-1 -> 0).
//   First sink with hdr_valid=1 is registered into grant_idx; go to HDR. No valid: stay.
// - HDR: source header fields/hdr_valid = sink[grant_idx]; sink[grant_idx].hdr_ready = source hdr_ready.
//   On the handshake go to PAYLOAD.
// - Latency: sink hdr_valid sampled in IDLE cycle N -> source hdr_valid in cycle N+1. One bubble cycle between frames.
// - PAYLOAD: combinational mux on registered grant_idx.
//   tdata/tvalid/tlast/tuser forwarded; tready returned only to the granted sink.
//   On tvalid&tready&tlast go to IDLE. Zero-cycle payload latency.
// - Ungranted sinks: hdr_ready=0 and tready=0 at all times. Their valid may be high indefinitely without effect.
// - Watchdog (TIMEOUT_CYCLES>0): counts PAYLOAD cycles with granted tvalid=0. Clears on any granted tvalid=1.
//   Reaching TIMEOUT_CYCLES -> ABORT, timeout_pulse=1.
//   Backpressure (tvalid=1, tready=0) never counts.
// - ABORT: source emits one beat tvalid=1, tlast=1, tuser=1, tdata=0.
//   Sink tready=0 meanwhile. Hold until source tready, then go to DRAIN.
// - DRAIN: sink[grant_idx].tready=1, source tvalid=0. Beats are discarded until a sink tlast beat, then IDLE.
// - Sink tlast arriving on the same cycle the watchdog expires: the tlast beat wins (forwarded), no abort.
// - Header handshake has no timeout. A requester that drops hdr_valid in HDR keeps the grant until it reasserts.
// - Grant is never revoked before tlast or abort. Round-robin gives each active requester a slot within PORT_COUNT frames.
// - Reset mid-frame: immediate return to reset values. The downstream frame is truncated without tlast.
//   This is accepted because the system reset also resets the stack.
// - The header interface carries hdr_valid/hdr_ready plus its field bundle. All fields are muxed as one group; no field is modified.
// STRUCTURE
// - udp_arb_pkg: typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, ABORT, DRAIN} arb_state_t.
//   Also a function for the round-robin next index.
// - Sub-module rr_arbiter #(N): req[N], last[$clog2(N)] -> gnt_idx, gnt_valid. Purely combinational rotating priority encoder.
// - Top holds the FSM, grant register, watchdog counter and the header/payload muxes (always_comb over the interface arrays).
// TESTING
// - Single request port 1: hdr_valid at cycle 10 -> source hdr_valid at 11; a 4-byte payload passes byte-exact; busy falls after tlast.
// - Ports 0,1,2 each keep 3 frames queued -> grant order 0,1,2,0,1,2,0,1,2.
//   No interleaving of bytes between frames; one idle cycle between frames.
// - Source tready held 0 for 2000 cycles mid-payload, TIMEOUT_CYCLES=1024 -> no abort, frame completes intact.
// - Port 2 stalls tvalid=0 for 1024 cycles after 5 bytes:
//   -> timeout_pulse once, extra beat with tlast=1/tuser=1 out, remaining 7 sink bytes drained with source tvalid=0, then port 0 granted.
// - Stall then tlast on exactly the expiry cycle -> tlast beat forwarded, timeout_pulse stays 0.
// - Assert reset during PAYLOAD of port 1 -> next cycle all valids/readies 0, grant_idx=PORT_COUNT-1.
//   After release, a port 0 request wins.

Source files
------------

// File: rtl/udp_arb_pkg.sv
// Shared types and helpers for the UDP TX frame arbiter.
package udp_arb_pkg;

  // Header field bundle: ip_dest(32) | src_port(16) | dst_port(16) | length(16)
  localparam int HDR_W = 80;

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, ABORT, DRAIN} arb_state_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority encoder: search starts just after last_i.
module rr_arbiter
  import udp_arb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_i,
  output logic [$clog2(N)-1:0] gnt_idx_o,
  output logic                 gnt_valid_o
);

  localparam int IW = $clog2(N);

  int pos;

  always_comb begin
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    pos         = int'(last_i);
    for (int i = 0; i < N; i++) begin
      pos = rr_next(pos, N);
      if (!gnt_valid_o && req_i[pos[IW-1:0]]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Frame-granular round-robin share of the UDP TX header+payload path, with a
// mid-frame stall watchdog that closes the frame as bad and drains the sender.
module udp_tx_arbiter
  import udp_arb_pkg::*;
#(
  parameter int PORT_COUNT     = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [PORT_COUNT-1:0]               sink_hdr_valid_i,
  output logic [PORT_COUNT-1:0]               sink_hdr_ready_o,
  input  logic [PORT_COUNT-1:0][HDR_W-1:0]    sink_hdr_fields_i,
  input  logic [PORT_COUNT-1:0][7:0]          sink_tdata_i,
  input  logic [PORT_COUNT-1:0]               sink_tvalid_i,
  input  logic [PORT_COUNT-1:0]               sink_tlast_i,
  input  logic [PORT_COUNT-1:0]               sink_tuser_i,
  output logic [PORT_COUNT-1:0]               sink_tready_o,
  output logic                                src_hdr_valid_o,
  input  logic                                src_hdr_ready_i,
  output logic [HDR_W-1:0]                    src_hdr_fields_o,
  output logic [7:0]                          src_tdata_o,
  output logic                                src_tvalid_o,
  output logic                                src_tlast_o,
  output logic                                src_tuser_o,
  input  logic                                src_tready_i,
  output logic [$clog2(PORT_COUNT)-1:0]       grant_idx,
  output logic                                busy,
  output logic                                timeout_pulse
);

  localparam int IW    = $clog2(PORT_COUNT);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_t       state_q, state_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             tpulse_q, tpulse_d;
  logic [IW-1:0]    rr_idx;
  logic             rr_valid;

  logic       sel_hdr_valid, sel_tvalid, sel_tlast, sel_tuser;
  logic [7:0] sel_tdata;

  rr_arbiter #(.N(PORT_COUNT)) u_rr (
    .req_i       (sink_hdr_valid_i),
    .last_i      (grant_q),
    .gnt_idx_o   (rr_idx),
    .gnt_valid_o (rr_valid)
  );

  assign sel_hdr_valid    = sink_hdr_valid_i[grant_q];
  assign sel_tvalid       = sink_tvalid_i[grant_q];
  assign sel_tlast        = sink_tlast_i[grant_q];
  assign sel_tuser        = sink_tuser_i[grant_q];
  assign sel_tdata        = sink_tdata_i[grant_q];
  assign src_hdr_fields_o = sink_hdr_fields_i[grant_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= IW'(PORT_COUNT - 1);
      wd_q     <= '0;
      tpulse_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      wd_q     <= wd_d;
      tpulse_q <= tpulse_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    wd_d             = wd_q;
    tpulse_d         = 1'b0;
    sink_hdr_ready_o = '0;
    sink_tready_o    = '0;
    src_hdr_valid_o  = 1'b0;
    src_tdata_o      = '0;
    src_tvalid_o     = 1'b0;
    src_tlast_o      = 1'b0;
    src_tuser_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        wd_d = '0;
        if (rr_valid) begin
          grant_d = rr_idx;
          state_d = HDR;
        end
      end
      HDR: begin
        src_hdr_valid_o           = sel_hdr_valid;
        sink_hdr_ready_o[grant_q] = src_hdr_ready_i;
        if (sel_hdr_valid && src_hdr_ready_i) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        src_tdata_o            = sel_tdata;
        src_tvalid_o           = sel_tvalid;
        src_tlast_o            = sel_tlast;
        src_tuser_o            = sel_tuser;
        sink_tready_o[grant_q] = src_tready_i;
        if (sel_tvalid) begin
          // Any presented beat, even backpressured, proves the sender is alive.
          wd_d = '0;
          if (src_tready_i && sel_tlast) state_d = IDLE;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (wd_q == WD_LAST) begin
            wd_d     = '0;
            tpulse_d = 1'b1;
            state_d  = ABORT;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end
      ABORT: begin
        src_tvalid_o = 1'b1;
        src_tlast_o  = 1'b1;
        src_tuser_o  = 1'b1;
        if (src_tready_i) state_d = DRAIN;
      end
      DRAIN: begin
        sink_tready_o[grant_q] = 1'b1;
        if (sel_tvalid && sel_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_idx     = grant_q;
  assign busy          = (state_q != IDLE);
  assign timeout_pulse = tpulse_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Randomized bench for udp_tx_arbiter against a frame-level reference model.
module tb_udp_tx_arbiter;
  import udp_arb_pkg::*;

  localparam int NP = 3;
  localparam int TO = 1024;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NP-1:0]            s_hdr_valid, s_hdr_ready, s_tvalid, s_tlast, s_tuser, s_tready;
  logic [NP-1:0][HDR_W-1:0] s_fields;
  logic [NP-1:0][7:0]       s_tdata;
  logic                     d_hdr_valid, d_hdr_ready, d_tvalid, d_tlast, d_tuser, d_tready;
  logic [HDR_W-1:0]         d_fields;
  logic [7:0]               d_tdata;
  logic [1:0]               grant_idx;
  logic                     busy, timeout_pulse;

  udp_tx_arbiter #(.PORT_COUNT(NP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .sink_hdr_valid_i(s_hdr_valid), .sink_hdr_ready_o(s_hdr_ready), .sink_hdr_fields_i(s_fields),
    .sink_tdata_i(s_tdata), .sink_tvalid_i(s_tvalid), .sink_tlast_i(s_tlast),
    .sink_tuser_i(s_tuser), .sink_tready_o(s_tready),
    .src_hdr_valid_o(d_hdr_valid), .src_hdr_ready_i(d_hdr_ready), .src_hdr_fields_o(d_fields),
    .src_tdata_o(d_tdata), .src_tvalid_o(d_tvalid), .src_tlast_o(d_tlast),
    .src_tuser_o(d_tuser), .src_tready_i(d_tready),
    .grant_idx(grant_idx), .busy(busy), .timeout_pulse(timeout_pulse)
  );

  typedef struct packed {
    logic [HDR_W-1:0] hdr;
    logic [4:0]       len;
    logic             bad;
    logic [15:0][7:0] data;
  } frame_t;

  typedef enum {M_ARB, M_HDR, M_PAY, M_ABORT, M_DRAIN} mph_t;

  frame_t fq [NP][$];
  bit     hdr_done [NP];
  bit     held [NP];
  int     d_idx [NP];
  int     stall_at [NP];
  int     stall_rem [NP];
  bit     gaps_en;
  int     rdy_mode;

  mph_t   mph;
  int     m_last, m_exp, m_idx, m_wd, drained, n_pulse;
  int     grant_log [$];
  int     errs = 0;
  int     checks = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic frame_t mk_frame(input int len, input bit bad);
    frame_t f;
    f.hdr = {$urandom, $urandom, 16'($urandom)};
    f.len = 5'(len);
    f.bad = bad;
    for (int i = 0; i < 16; i++) f.data[i] = 8'($urandom);
    return f;
  endfunction

  function automatic logic [NP-1:0] onehot(input int p);
    logic [NP-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick(input logic [NP-1:0] req, input int last);
    for (int k = 1; k <= NP; k++) begin
      int p;
      p = (last + k) % NP;
      if (req[p]) return p;
    end
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int p = 0; p < NP; p++) if (fq[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_drivers();
    for (int p = 0; p < NP; p++) begin
      fq[p].delete();
      hdr_done[p] = 1'b0; held[p] = 1'b0; d_idx[p] = 0;
      stall_at[p] = -1; stall_rem[p] = 0;
    end
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      s_hdr_valid[p] = 1'b0; s_fields[p] = '0; s_tvalid[p] = 1'b0;
      s_tlast[p] = 1'b0; s_tuser[p] = 1'b0; s_tdata[p] = '0;
      if (fq[p].size() != 0) begin
        frame_t f;
        f = fq[p][0];
        if (!hdr_done[p]) begin
          s_hdr_valid[p] = 1'b1;
          s_fields[p]    = f.hdr;
        end else begin
          s_tdata[p] = f.data[d_idx[p]];
          s_tlast[p] = (d_idx[p] == int'(f.len) - 1);
          s_tuser[p] = f.bad;
          if (held[p]) s_tvalid[p] = 1'b1;
          else if (d_idx[p] == stall_at[p] && stall_rem[p] > 0) begin
            stall_rem[p]--;
            s_tvalid[p] = 1'b0;
          end else s_tvalid[p] = gaps_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
      end
    end
    d_tready    = (rdy_mode == 0) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
    d_hdr_ready = (rdy_mode == 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
  endtask

  task automatic observe();
    frame_t f;
    if (timeout_pulse) n_pulse++;
    case (mph)
      M_ARB: begin
        int pick;
        check_val("arb_busy", busy, 0);
        check_val("arb_src_hvld", d_hdr_valid, 0);
        check_val("arb_src_tvld", d_tvalid, 0);
        check_val("arb_readies", {s_hdr_ready, s_tready}, 0);
        pick = rr_pick(s_hdr_valid, m_last);
        if (pick >= 0) begin
          m_exp = pick; m_last = pick; m_idx = 0; m_wd = 0; mph = M_HDR;
        end
      end
      M_HDR: begin
        f = fq[m_exp][0];
        check_val("hdr_busy", busy, 1);
        check_val("hdr_grant", grant_idx, m_exp);
        check_val("hdr_src_hvld", d_hdr_valid, 1);
        check_val("hdr_fields", d_fields, f.hdr);
        check_val("hdr_sink_hrdy", s_hdr_ready, d_hdr_ready ? onehot(m_exp) : '0);
        check_val("hdr_sink_trdy", s_tready, 0);
        check_val("hdr_src_tvld", d_tvalid, 0);
        if (d_hdr_ready) begin
          grant_log.push_back(m_exp);
          mph = M_PAY;
        end
      end
      M_PAY: begin
        f = fq[m_exp][0];
        check_val("pay_tvalid", d_tvalid, s_tvalid[m_exp]);
        check_val("pay_sink_trdy", s_tready, d_tready ? onehot(m_exp) : '0);
        check_val("pay_sink_hrdy", s_hdr_ready, 0);
        if (s_tvalid[m_exp]) begin
          m_wd = 0;
          check_val("pay_tdata", d_tdata, f.data[m_idx]);
          check_val("pay_tlast", d_tlast, m_idx == int'(f.len) - 1);
          check_val("pay_tuser", d_tuser, f.bad);
          if (d_tready) begin
            if (m_idx == int'(f.len) - 1) mph = M_ARB;
            m_idx++;
          end
        end else begin
          m_wd++;
          if (m_wd == TO) mph = M_ABORT;
        end
      end
      M_ABORT: begin
        check_val("abort_beat", {d_tvalid, d_tlast, d_tuser, d_tdata}, {3'b111, 8'h00});
        check_val("abort_sink_trdy", s_tready, 0);
        if (d_tready) mph = M_DRAIN;
      end
      M_DRAIN: begin
        f = fq[m_exp][0];
        check_val("drain_src_tvld", d_tvalid, 0);
        check_val("drain_sink_trdy", s_tready, onehot(m_exp));
        if (s_tvalid[m_exp]) begin
          drained++;
          if (m_idx == int'(f.len) - 1) mph = M_ARB;
          m_idx++;
        end
      end
      default: mph = M_ARB;
    endcase
    for (int p = 0; p < NP; p++) begin
      if (fq[p].size() != 0) begin
        if (s_hdr_valid[p] && s_hdr_ready[p]) hdr_done[p] = 1'b1;
        if (s_tvalid[p] && s_tready[p]) begin
          if (s_tlast[p]) begin
            void'(fq[p].pop_front());
            hdr_done[p] = 1'b0; d_idx[p] = 0; stall_at[p] = -1; stall_rem[p] = 0;
          end else d_idx[p]++;
        end
        held[p] = s_tvalid[p] && !s_tready[p];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    observe();
  endtask

  task automatic run_idle(input int maxc, input string tag);
    int n;
    n = 0;
    while (!(all_empty() && mph == M_ARB) && n < maxc) begin
      step();
      n++;
    end
    check_val({tag, "_finished"}, n < maxc, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    clear_drivers();
    gaps_en = 1'b1; rdy_mode = 0;
    mph = M_ARB; m_last = NP - 1; m_exp = 0; m_idx = 0; m_wd = 0; drained = 0; n_pulse = 0;
    reset = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_grant", grant_idx, NP - 1);
    check_val("rst_pulse", timeout_pulse, 0);
    check_val("rst_src_valids", {d_hdr_valid, d_tvalid}, 0);
    check_val("rst_sink_readies", {s_hdr_ready, s_tready}, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Round robin with three frames queued per port
    grant_log.delete();
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < NP; p++) fq[p].push_back(mk_frame($urandom_range(1, 16), 1'($urandom)));
    run_idle(3000, "rr");
    check_val("rr_count", grant_log.size(), 9);
    for (int i = 0; i < 9 && i < grant_log.size(); i++) check_val("rr_order", grant_log[i], i % 3);

    // Single port 1 request, 4-byte payload
    repeat (10) step();
    fq[1].push_back(mk_frame(4, 1'b0));
    run_idle(200, "single");
    check_val("single_grant", grant_log[grant_log.size() - 1], 1);

    // Long downstream backpressure mid-payload must not trip the watchdog
    gaps_en = 1'b0; rdy_mode = 1;
    fq[0].push_back(mk_frame(10, 1'b0));
    n = 0;
    while (!(mph == M_PAY && m_idx >= 4) && n < 200) begin step(); n++; end
    check_val("bp_reached", n < 200, 1);
    rdy_mode = 2;
    repeat (2000) step();
    rdy_mode = 1;
    run_idle(200, "bp");
    check_val("bp_no_pulse", n_pulse, 0);

    // Port 2 stalls after 5 bytes long enough to be aborted
    fq[2].push_back(mk_frame(12, 1'b0));
    stall_at[2] = 5; stall_rem[2] = 1100;
    n = 0;
    while (mph != M_PAY && n < 200) begin step(); n++; end
    check_val("abort_reached", n < 200, 1);
    fq[0].push_back(mk_frame(3, 1'b1));
    run_idle(3000, "abort");
    check_val("abort_pulses", n_pulse, 1);
    check_val("abort_drained", drained, 7);
    check_val("abort_then_port0", grant_log[grant_log.size() - 1], 0);
    check_val("abort_was_port2", grant_log[grant_log.size() - 2], 2);

    // tlast arrives on the very cycle the watchdog would expire
    fq[2].push_back(mk_frame(6, 1'b0));
    stall_at[2] = 5; stall_rem[2] = TO - 1;
    run_idle(2000, "expiry");
    check_val("expiry_no_pulse", n_pulse, 1);
    check_val("expiry_grant", grant_log[grant_log.size() - 1], 2);

    // Reset during port 1 payload
    fq[1].push_back(mk_frame(8, 1'b0));
    stall_at[1] = 3; stall_rem[1] = 500;
    n = 0;
    while (!(mph == M_PAY && m_idx == 3) && n < 200) begin step(); n++; end
    check_val("rst_mid_reached", n < 200, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_drivers();
    drive();
    @(negedge clk);
    check_val("rst_mid_valids", {d_hdr_valid, d_tvalid}, 0);
    check_val("rst_mid_readies", {s_hdr_ready, s_tready}, 0);
    check_val("rst_mid_grant", grant_idx, NP - 1);
    check_val("rst_mid_busy", busy, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    mph = M_ARB; m_last = NP - 1;
    gaps_en = 1'b1; rdy_mode = 0;
    fq[1].push_back(mk_frame(5, 1'b0));
    fq[0].push_back(mk_frame(5, 1'b1));
    run_idle(500, "post_rst");
    check_val("post_rst_first", grant_log[grant_log.size() - 2], 0);
    check_val("post_rst_second", grant_log[grant_log.size() - 1], 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
